// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle control unit and its datapath.
// The controller takes the master side: it reads opcode/zero/imem_ready
// and drives every enable and mux select. The datapath takes the slave side.
interface multicycle_ctrl_if #(
    parameter int OPW = 6
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           imem_ready;
    logic           imem_req;
    logic           ir_en;
    logic           pc_en;
    logic           pc_src;
    logic           we3;
    logic           wd_src;
    logic [2:0]     alu_op;
    logic           z_load;
    logic           halted;
    logic [2:0]     state;

    modport master (
        input  opcode,
        input  zero,
        input  imem_ready,
        output imem_req,
        output ir_en,
        output pc_en,
        output pc_src,
        output we3,
        output wd_src,
        output alu_op,
        output z_load,
        output halted,
        output state
    );

    modport slave (
        output opcode,
        output zero,
        output imem_ready,
        input  imem_req,
        input  ir_en,
        input  pc_en,
        input  pc_src,
        input  we3,
        input  wd_src,
        input  alu_op,
        input  z_load,
        input  halted,
        input  state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control unit of the multicycle CPU. Sequences each instruction
// through fetch, decode, execute, write-back and jump phases and holds
// off in FETCH for as many instruction-memory wait states as needed.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | request instruction; on imem_ready load IR and bump PC
// DECODE | register file operand read; pick next phase from opcode class
// EXEC   | ALU operation, zero flag loaded
// WB     | register file write (ALU result or immediate)
// JUMP   | conditional/unconditional PC load from jump target
// HALT   | everything idle until reset
module multicycle_ctrl #(
    parameter int OPW = 6
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        JUMP   = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LIMM = 2'b01;
    localparam logic [1:0] CLS_JMP  = 2'b10;

    localparam logic [1:0] JMP_J   = 2'b00;
    localparam logic [1:0] JMP_JZ  = 2'b01;
    localparam logic [1:0] JMP_JNZ = 2'b10;
    localparam logic [1:0] JMP_NOP = 2'b11;

    state_t     state_q;
    state_t     state_d;

    // Instruction attributes captured during the instruction so WB does not
    // depend on what the IR bits look like after the execute phase.
    logic       is_limm_q;
    logic [2:0] alu_op_q;

    logic [1:0] op_cls;
    logic [2:0] op_func;
    logic       op_halt;
    logic       jump_taken;

    logic       imem_req_c;
    logic       ir_en_c;
    logic       pc_en_c;
    logic       pc_src_c;
    logic       we3_c;
    logic       wd_src_c;
    logic [2:0] alu_op_c;
    logic       z_load_c;
    logic       halted_c;

    assign op_cls  = bus.opcode[OPW-1:OPW-2];
    assign op_func = bus.opcode[2:0];
    assign op_halt = (bus.opcode == {OPW{1'b1}});

    // Jump condition evaluated against the flag left by the last ALU EXEC.
    always_comb begin
        jump_taken = 1'b0;
        case (op_func[1:0])
            JMP_J:   jump_taken = 1'b1;
            JMP_JZ:  jump_taken = bus.zero;
            JMP_JNZ: jump_taken = ~bus.zero;
            default: jump_taken = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-instruction attributes: write-data source at DECODE, ALU code at EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_limm_q <= 1'b0;
            alu_op_q  <= 3'd0;
        end else begin
            if (state_q == DECODE) begin
                is_limm_q <= (op_cls == CLS_LIMM);
            end
            if (state_q == EXEC) begin
                alu_op_q <= op_func;
            end
        end
    end

    // Next-state and control outputs for the current state.
    always_comb begin
        state_d    = state_q;
        imem_req_c = 1'b0;
        ir_en_c    = 1'b0;
        pc_en_c    = 1'b0;
        pc_src_c   = 1'b0;
        we3_c      = 1'b0;
        wd_src_c   = 1'b0;
        alu_op_c   = 3'd0;
        z_load_c   = 1'b0;
        halted_c   = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_en_c = 1'b1;
                    pc_en_c = 1'b1;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                case (op_cls)
                    CLS_ALU:  state_d = EXEC;
                    CLS_LIMM: state_d = WB;
                    CLS_JMP:  state_d = (op_func[1:0] == JMP_NOP) ? FETCH : JUMP;
                    default:  state_d = op_halt ? HALT : FETCH;
                endcase
            end

            EXEC: begin
                alu_op_c = op_func;
                z_load_c = 1'b1;
                state_d  = WB;
            end

            WB: begin
                we3_c    = 1'b1;
                wd_src_c = is_limm_q;
                alu_op_c = is_limm_q ? 3'd0 : alu_op_q;
                state_d  = FETCH;
            end

            JUMP: begin
                if (jump_taken) begin
                    pc_en_c  = 1'b1;
                    pc_src_c = 1'b1;
                end
                state_d = FETCH;
            end

            HALT: begin
                halted_c = 1'b1;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Reset gates every output so nothing strobes the datapath while held,
    // including a combinational fetch that would otherwise see imem_ready.
    always_comb begin
        bus.imem_req = reset & imem_req_c;
        bus.ir_en    = reset & ir_en_c;
        bus.pc_en    = reset & pc_en_c;
        bus.pc_src   = reset & pc_src_c;
        bus.we3      = reset & we3_c;
        bus.wd_src   = reset & wd_src_c;
        bus.alu_op   = reset ? alu_op_c : 3'd0;
        bus.z_load   = reset & z_load_c;
        bus.halted   = reset & halted_c;
        bus.state    = reset ? state_q : 3'd0;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for the multicycle control unit. Outputs are packed into
// one vector {imem_req, ir_en, pc_en, pc_src, we3, wd_src, alu_op, z_load,
// halted, state} and compared against hand-built expected vectors.
module tb_multicycle_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    multicycle_ctrl_if #(.OPW(6)) bus ();

    multicycle_ctrl #(.OPW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [13:0] obs;
    assign obs = {bus.imem_req, bus.ir_en, bus.pc_en, bus.pc_src, bus.we3,
                  bus.wd_src, bus.alu_op, bus.z_load, bus.halted, bus.state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] v(input logic req, input logic ir,
                                      input logic pc, input logic src,
                                      input logic we, input logic wd,
                                      input logic [2:0] op, input logic zl,
                                      input logic h, input logic [2:0] st);
        return {req, ir, pc, src, we, wd, op, zl, h, st};
    endfunction

    function automatic logic [13:0] f_go();
        return v(1, 1, 1, 0, 0, 0, 3'd0, 0, 0, 3'd0);
    endfunction

    function automatic logic [13:0] f_idle();
        return v(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd0);
    endfunction

    function automatic logic [13:0] f_dec();
        return v(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd1);
    endfunction

    task automatic test_reset();
        logic [13:0] ev [3];
        logic [0:2]  rdy;
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        bus.opcode = 6'b110000;
        bus.zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 14'd0) begin
                failures++;
                $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, 14'd0);
            end
        end
        reset = 1'b1;
        ev  = '{f_go(), f_dec(), f_idle()};
        rdy = 3'b100;
        for (int i = 0; i < 3; i++) begin
            bus.imem_ready = rdy[i]; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL reset_release step %0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_wait();
        logic [13:0] ev [6];
        logic [0:5]  rdy;
        bus.opcode = 6'b110000;
        ev  = '{f_idle(), f_idle(), f_idle(), f_go(), f_dec(), f_idle()};
        rdy = 6'b000100;
        for (int i = 0; i < 6; i++) begin
            bus.imem_ready = rdy[i]; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL fetch_wait step %0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        logic [13:0] ev [5];
        logic [0:4]  rdy;
        bus.opcode = 6'b000101;
        ev  = '{f_go(), f_dec(),
                v(0, 0, 0, 0, 0, 0, 3'b101, 1, 0, 3'd2),
                v(0, 0, 0, 0, 1, 0, 3'b101, 0, 0, 3'd3),
                f_idle()};
        rdy = 5'b11110;
        for (int i = 0; i < 5; i++) begin
            bus.imem_ready = rdy[i]; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL alu step %0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        logic [5:0]  ops   [5];
        logic [0:4]  zeros;
        logic [0:4]  taken;
        logic [13:0] ev    [4];
        logic [0:3]  rdy;
        ops   = '{6'b100001, 6'b100001, 6'b100010, 6'b100010, 6'b100000};
        zeros = 5'b10100;
        taken = 5'b10011;
        rdy   = 4'b1110;
        for (int j = 0; j < 5; j++) begin
            bus.opcode = ops[j];
            bus.zero   = zeros[j];
            ev = '{f_go(), f_dec(),
                   taken[j] ? v(0, 0, 1, 1, 0, 0, 3'd0, 0, 0, 3'd4)
                            : v(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd4),
                   f_idle()};
            for (int i = 0; i < 4; i++) begin
                bus.imem_ready = rdy[i]; #1;
                checks++;
                if (obs !== ev[i]) begin
                    failures++;
                    $display("FAIL jump op=%b zero=%b step %0d: got %b want %b",
                             ops[j], zeros[j], i, obs, ev[i]);
                end
                @(posedge clk); #1;
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_limm();
        logic [13:0] ev [4];
        logic [0:3]  rdy;
        bus.opcode = 6'b010000;
        ev  = '{f_go(), f_dec(), v(0, 0, 0, 0, 1, 1, 3'd0, 0, 0, 3'd3), f_idle()};
        rdy = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = rdy[i]; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL limm step %0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nop();
        logic [5:0]  ops [2];
        logic [13:0] ev  [3];
        logic [0:2]  rdy;
        ops = '{6'b110000, 6'b100011};
        ev  = '{f_go(), f_dec(), f_idle()};
        rdy = 3'b110;
        for (int j = 0; j < 2; j++) begin
            bus.opcode = ops[j];
            for (int i = 0; i < 3; i++) begin
                bus.imem_ready = rdy[i]; #1;
                checks++;
                if (obs !== ev[i]) begin
                    failures++;
                    $display("FAIL nop op=%b step %0d: got %b want %b", ops[j], i, obs, ev[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_halt();
        logic [13:0] exp_v;
        bus.opcode = 6'b111111;
        for (int i = 0; i < 22; i++) begin
            bus.imem_ready = (i < 2) ? 1'b1 : logic'(i % 2);
            exp_v = (i == 0) ? f_go() : (i == 1) ? f_dec()
                             : v(0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 3'd5);
            #1;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL halt step %0d: got %b want %b", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] ev [3];
        // Leave HALT through reset; it must take effect without a clock edge.
        reset = 1'b0; #1;
        checks++;
        if (obs !== 14'd0) begin
            failures++;
            $display("FAIL halt_exit_reset: got %b want %b", obs, 14'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.opcode = 6'b000011;
        ev = '{f_go(), f_dec(), v(0, 0, 0, 0, 0, 0, 3'b011, 1, 0, 3'd2)};
        for (int i = 0; i < 3; i++) begin
            bus.imem_ready = 1'b1; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL reset_mid pre step %0d: got %b want %b", i, obs, ev[i]);
            end
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid in_exec: got %b want %b", obs, 14'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid held: got %b want %b", obs, 14'd0);
        end
        reset = 1'b1;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs !== f_idle()) begin
                failures++;
                $display("FAIL reset_mid after step %0d: got %b want %b", i, obs, f_idle());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] ev [8];
        logic [0:7]  rdy;
        bus.opcode = 6'b000110;
        ev  = '{f_go(), f_dec(),
                v(0, 0, 0, 0, 0, 0, 3'b110, 1, 0, 3'd2),
                v(0, 0, 0, 0, 1, 0, 3'b110, 0, 0, 3'd3),
                f_go(), f_dec(),
                v(0, 0, 0, 0, 1, 1, 3'd0, 0, 0, 3'd3),
                f_idle()};
        rdy = 8'b11111110;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.opcode = 6'b010000;
            bus.imem_ready = rdy[i]; #1;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL back_to_back step %0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.imem_ready = 1'b0;
        bus.opcode = 6'd0;
        bus.zero   = 1'b0;
        test_reset();
        test_fetch_wait();
        test_alu();
        test_jump();
        test_limm();
        test_nop();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
